axi_stream_rr_packet_arbiter: RTL and testbench
===============================================

// Module: axi_stream_rr_packet_arbiter
// PURPOSE
//  Packet-granular round-robin arbiter sharing one AXI-Stream output among NB_SRC source streams.
//  Sources are typically file-driven stream generators (matrix A/B operand feeds).
//  Sink is the single operand port of the systolic MMM array.
//  Once granted, a source owns the output until its tlast beat is accepted. Output is registered.
// PARAMETERS
//  WIDTH    32  tdata width of every source and of the output
//  NB_SRC   2   number of source streams (>=2)
//  ID_W     $clog2(NB_SRC) (localparam)  width of m_axis_tid
// PORTS
//  clk            in   1             single clock for all interfaces
//  rst            in   1             synchronous, active-high reset
//  s_axis_tvalid  in   NB_SRC        per-source valid
//  s_axis_tdata   in   NB_SRC*WIDTH  flattened; source i at [i*WIDTH +: WIDTH]
//  s_axis_tlast   in   NB_SRC        per-source end of packet
//  s_axis_tready  out  NB_SRC        per-source ready; at most one bit high (one-hot or zero)
//  m_axis_tvalid  out  1             output valid
//  m_axis_tdata   out  WIDTH         output data
//  m_axis_tstrb   out  (WIDTH+7)/8   constant all ones
//  m_axis_tlast   out  1             output end of packet
//  m_axis_tid     out  ID_W          index of the source that produced the beat
//  m_axis_tready  in   1             downstream ready
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - state=IDLE; m_axis_tvalid/tlast/tdata/tid = 0; s_axis_tready = 0
//   - rr pointer = NB_SRC-1, so source 0 wins first
//   - Mid-packet reset discards the in-flight beat and the grant; no tlast is emitted
//  FSM IDLE:
//   - Requests = s_axis_tvalid. Winner = first requester searching from ptr+1 upward, modulo NB_SRC
//   - If any request: grant<=winner, ptr<=winner, ->GRANT. No beat is accepted in IDLE
//  FSM GRANT:
//   - s_axis_tready[grant] = !m_axis_tvalid || m_axis_tready; all other tready bits 0
//   - Accepted beat (valid&ready): register tdata/tlast/tid, m_axis_tvalid<=1 next cycle
//   - Latency: input handshake to output valid = 1 cycle
//   - Output held stable while m_axis_tvalid && !m_axis_tready (AXIS rule)
//   - Output clears when accepted and no new beat arrives
//   - Accepted beat with tlast=1: ->IDLE; grant released the same edge
//   - Packet switch costs one bubble cycle (IDLE arbitration)
//  Throughput: 1 beat/cycle inside a packet with continuous valid/ready
//  Grant holds across source valid gaps; the arbiter never preempts a packet
//  Single requester repeatedly sending: re-granted after each bubble (ptr wraps to itself)
//  m_axis_tid ranges 0..NB_SRC-1; ptr increment wraps NB_SRC-1 -> 0
//  tdata/tlast of non-granted sources are ignored; their valid may stay high indefinitely
// CONFIGURATION
//  AXIS_ARB_PKT_COUNT_EN defined:
//   - Adds output pkt_count [NB_SRC*16] (source i at [i*16 +: 16])
//   - Counter i increments on each output tlast beat accepted downstream with tid==i
//   - Counters wrap at 16 bits and reset to 0
//  AXIS_ARB_PKT_COUNT_EN undefined: port and counters absent; all else identical
// TESTING
//  T1: NB_SRC=2, src0 sends 4-beat pkt 0x10..0x13, tready=1 -> out 0x10..0x13, tid=0, tlast on 0x13, 1-cycle latency
//  T2: both valid at once, 3-beat pkts each -> src0 pkt, 1 bubble, src1 pkt, then src0 again (strict alternation)
//  T3: m_axis_tready toggles 1,0,0,1 mid-packet -> no beat lost/duplicated; data stable while stalled
//  T4: src1 drops valid 2 cycles mid-packet while src0 valid -> grant stays on src1; src0 tready stays 0
//  T5: rst=1 one cycle during beat 2 of 5 -> next cycle m_axis_tvalid=0, tready=0; next grant goes to src0
//  T6 (AXIS_ARB_PKT_COUNT_EN): 3 pkts src0, 2 pkts src1 -> pkt_count = {16'd2,16'd3}; without macro builds with no port

Source files
------------

// File: rtl/axi_stream_rr_packet_arbiter.sv
// Packet-granular round-robin arbiter: NB_SRC AXI-Stream sources share one registered output.
// Define AXIS_ARB_PKT_COUNT_EN to add per-source 16-bit packet counters on output pkt_count.
module axi_stream_rr_packet_arbiter #(
  parameter int  WIDTH  = 32,
  parameter int  NB_SRC = 2,
  localparam int ID_W   = $clog2(NB_SRC),
  localparam int STRB_W = (WIDTH + 7) / 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NB_SRC-1:0]       s_axis_tvalid,
  input  logic [NB_SRC*WIDTH-1:0] s_axis_tdata,
  input  logic [NB_SRC-1:0]       s_axis_tlast,
  output logic [NB_SRC-1:0]       s_axis_tready,
  output logic                    m_axis_tvalid,
  output logic [WIDTH-1:0]        m_axis_tdata,
  output logic [STRB_W-1:0]       m_axis_tstrb,
  output logic                    m_axis_tlast,
  output logic [ID_W-1:0]         m_axis_tid,
`ifdef AXIS_ARB_PKT_COUNT_EN
  output logic [NB_SRC*16-1:0]    pkt_count,
`endif
  input  logic                    m_axis_tready
);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_e;

  state_e           state_q;
  logic [ID_W-1:0]  grant_q;
  logic [ID_W-1:0]  ptr_q;
  logic [ID_W-1:0]  m_tid_q;
  logic             m_valid_q;
  logic             m_last_q;
  logic [WIDTH-1:0] m_data_q;

  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  cand;
  logic             found;
  logic             grant_rdy;
  logic             beat_acc;
  logic             out_acc;
  logic             sel_last;
  logic [WIDTH-1:0] sel_data;

  // The output register can take a new beat whenever it is empty or being drained.
  assign grant_rdy = !m_valid_q || m_axis_tready;
  assign out_acc   = m_valid_q && m_axis_tready;
  assign sel_data  = s_axis_tdata[int'(grant_q)*WIDTH +: WIDTH];
  assign sel_last  = s_axis_tlast[grant_q];
  assign beat_acc  = (state_q == GRANT) && s_axis_tvalid[grant_q] && grant_rdy;

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tid    = m_tid_q;
  assign m_axis_tstrb  = {STRB_W{1'b1}};

  // Round-robin search starting just above the last winner; the pointer itself is checked last.
  always_comb begin
    winner = {ID_W{1'b0}};
    cand   = {ID_W{1'b0}};
    found  = 1'b0;
    for (int k = 1; k <= NB_SRC; k++) begin
      cand = ID_W'((int'(ptr_q) + k) % NB_SRC);
      if (!found && s_axis_tvalid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end else begin
        found  = found;
      end
    end
  end

  // Only the granted source sees ready, and only while a packet is owned.
  always_comb begin
    s_axis_tready = {NB_SRC{1'b0}};
    if (state_q == GRANT) begin
      s_axis_tready[grant_q] = grant_rdy;
    end else begin
      s_axis_tready = {NB_SRC{1'b0}};
    end
  end

  // Arbitration FSM with the registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= {ID_W{1'b0}};
      ptr_q     <= ID_W'(NB_SRC - 1);
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= {WIDTH{1'b0}};
      m_tid_q   <= {ID_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (out_acc) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
          end
          if (found) begin
            grant_q <= winner;
            ptr_q   <= winner;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (beat_acc) begin
            m_valid_q <= 1'b1;
            m_data_q  <= sel_data;
            m_last_q  <= sel_last;
            m_tid_q   <= grant_q;
            if (sel_last) begin
              state_q <= IDLE;
            end
          end else if (out_acc) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef AXIS_ARB_PKT_COUNT_EN
  logic [15:0] cnt_q [NB_SRC];

  // A packet counts once its tlast beat leaves on the output port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NB_SRC; i++) begin
        cnt_q[i] <= 16'd0;
      end
    end else if (out_acc && m_last_q) begin
      cnt_q[m_tid_q] <= cnt_q[m_tid_q] + 16'd1;
    end
  end

  for (genvar g = 0; g < NB_SRC; g++) begin : g_cnt
    assign pkt_count[g*16 +: 16] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_axi_stream_rr_packet_arbiter.sv
// Self-checking bench for axi_stream_rr_packet_arbiter: directed phases with randomized
// valid/ready activity, checked cycle by cycle against a transaction-level reference model.
module tb_axi_stream_rr_packet_arbiter;
  localparam int NB = 2;
  localparam int W  = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [NB-1:0]   tv;
  logic [NB*W-1:0] td;
  logic [NB-1:0]   tl;
  logic [NB-1:0]   s_axis_tready;
  logic            m_axis_tvalid;
  logic [W-1:0]    m_axis_tdata;
  logic [3:0]      m_axis_tstrb;
  logic            m_axis_tlast;
  logic [0:0]      m_axis_tid;
  logic            mrdy;
`ifdef AXIS_ARB_PKT_COUNT_EN
  logic [NB*16-1:0] pkt_count;
`endif

  axi_stream_rr_packet_arbiter #(.WIDTH(W), .NB_SRC(NB)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(tv), .s_axis_tdata(td), .s_axis_tlast(tl), .s_axis_tready(s_axis_tready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb),
    .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
`ifdef AXIS_ARB_PKT_COUNT_EN
    .pkt_count(pkt_count),
`endif
    .m_axis_tready(mrdy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference model: owner of the output (-1 = nobody), last winner, one-beat output slot
  int          owner;
  int          ptr;
  bit          mv;
  bit          ml;
  logic [W-1:0] md;
  int          mt;
  logic [15:0] cnt [NB];
  logic [NB-1:0] exp_rdy;

  // source generators
  int          pkts_left [NB];
  int          beat_idx  [NB];
  int          cur_len   [NB];
  int          force_len [NB];
  bit          hold      [NB];
  logic [W-1:0] dctr     [NB];
  int          vprob;
  int          rprob;

  // beats seen leaving the DUT
  int          log_tid  [$];
  logic [W-1:0] log_data [$];
  bit          log_last [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1;
    ptr   = NB - 1;
    mv    = 1'b0;
    ml    = 1'b0;
    md    = '0;
    mt    = 0;
    for (int i = 0; i < NB; i++) cnt[i] = 16'd0;
  endtask

  task automatic new_len(input int i);
    cur_len[i] = (force_len[i] > 0) ? force_len[i] : int'($urandom_range(5, 1));
  endtask

  task automatic src_advance(input int i);
    dctr[i] = dctr[i] + 32'd1;
    hold[i] = 1'b0;
    if (beat_idx[i] == cur_len[i] - 1) begin
      beat_idx[i]  = 0;
      pkts_left[i] = pkts_left[i] - 1;
      new_len(i);
    end else begin
      beat_idx[i] = beat_idx[i] + 1;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NB; i++) begin
      if (pkts_left[i] > 0 && (hold[i] || int'($urandom_range(99, 0)) < vprob)) begin
        tv[i]           = 1'b1;
        td[i*W +: W]    = dctr[i];
        tl[i]           = (beat_idx[i] == cur_len[i] - 1);
        hold[i]         = 1'b1;
      end else begin
        tv[i]           = 1'b0;
        td[i*W +: W]    = $urandom;
        tl[i]           = 1'($urandom_range(1, 0));
      end
    end
    mrdy = (int'($urandom_range(99, 0)) < rprob);
  endtask

  task automatic cycle();
    bit out_acc;
    drive();
    #1;
    exp_rdy = '0;
    if (owner >= 0 && (!mv || mrdy)) exp_rdy[owner] = 1'b1;
    chk("s_tready", 64'(s_axis_tready), 64'(exp_rdy));
    chk("m_tvalid", 64'(m_axis_tvalid), 64'(mv));
    chk("m_tstrb", 64'(m_axis_tstrb), 64'hF);
    if (mv) begin
      chk("m_tdata", 64'(m_axis_tdata), 64'(md));
      chk("m_tlast", 64'(m_axis_tlast), 64'(ml));
      chk("m_tid", 64'(m_axis_tid), 64'(mt));
    end
`ifdef AXIS_ARB_PKT_COUNT_EN
    chk("pkt_count", 64'(pkt_count), 64'({cnt[1], cnt[0]}));
`endif
    if (m_axis_tvalid === 1'b1 && mrdy) begin
      log_tid.push_back(int'(m_axis_tid));
      log_data.push_back(m_axis_tdata);
      log_last.push_back(m_axis_tlast);
    end
    @(posedge clk);
    out_acc = mv && mrdy;
    for (int i = 0; i < NB; i++) if (tv[i] && exp_rdy[i]) src_advance(i);
    if (rst) begin
      model_reset();
    end else begin
      if (out_acc && ml) cnt[mt] = cnt[mt] + 16'd1;
      if (owner < 0) begin
        if (out_acc) begin mv = 1'b0; ml = 1'b0; end
        for (int k = 1; k <= NB; k++) begin
          if (owner < 0 && tv[(ptr + k) % NB]) owner = (ptr + k) % NB;
        end
        if (owner >= 0) ptr = owner;
      end else if (tv[owner] && exp_rdy[owner]) begin
        md = td[owner*W +: W];
        ml = tl[owner];
        mt = owner;
        mv = 1'b1;
        if (tl[owner]) owner = -1;
      end else if (out_acc) begin
        mv = 1'b0;
        ml = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    log_tid.delete();
    log_data.delete();
    log_last.delete();
  endtask

  task automatic setup_src(input int i, input int pkts, input int flen, input logic [W-1:0] d0);
    pkts_left[i] = pkts;
    force_len[i] = flen;
    beat_idx[i]  = 0;
    hold[i]      = 1'b0;
    dctr[i]      = d0;
    new_len(i);
  endtask

  initial begin
    int exp_tids [9];
    int first;
    rst = 1'b1;
    tv = '0; tl = '0; td = '0; mrdy = 1'b0;
    vprob = 100; rprob = 100;
    for (int i = 0; i < NB; i++) setup_src(i, 0, 0, 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    do_reset();

    // T1: single 4-beat packet from source 0
    setup_src(0, 1, 4, 32'h10);
    run(10);
    chk("t1_beats", 64'(log_data.size()), 64'd4);
    for (int k = 0; k < 4 && k < log_data.size(); k++) begin
      chk("t1_data", 64'(log_data[k]), 64'h10 + 64'(k));
      chk("t1_tid", 64'(log_tid[k]), 64'd0);
      chk("t1_last", 64'(log_last[k]), 64'(k == 3));
    end

    // T2: both sources requesting continuously, 3-beat packets, strict alternation
    do_reset();
    setup_src(0, 2, 3, 32'h100);
    setup_src(1, 1, 3, 32'h200);
    run(20);
    exp_tids = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
    chk("t2_beats", 64'(log_tid.size()), 64'd9);
    for (int k = 0; k < 9 && k < log_tid.size(); k++) chk("t2_tid", 64'(log_tid[k]), 64'(exp_tids[k]));

    // T3/T4: random valid gaps and downstream stalls
    setup_src(0, 8, 0, 32'h1000);
    setup_src(1, 8, 0, 32'h2000);
    vprob = 60; rprob = 50;
    run(300);
    vprob = 100; rprob = 100;
    for (int n = 0; n < 300 && (pkts_left[0] + pkts_left[1]) > 0; n++) cycle();
    chk("drain_timeout", 64'(pkts_left[0] + pkts_left[1]), 64'd0);
    run(4);

    // T5: reset in the middle of a 5-beat packet while source 1 is also waiting
    do_reset();
    setup_src(0, 1, 5, 32'h300);
    run(3);
    setup_src(1, 1, 2, 32'h400);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t5_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("t5_tready", 64'(s_axis_tready), 64'd0);
    log_tid.delete(); log_data.delete(); log_last.delete();
    run(15);
    first = (log_tid.size() > 0) ? log_tid[0] : -1;
    chk("t5_first_grant", 64'(first), 64'd0);

`ifdef AXIS_ARB_PKT_COUNT_EN
    // T6: packet counters
    do_reset();
    setup_src(0, 3, 2, 32'h500);
    setup_src(1, 2, 2, 32'h600);
    run(40);
    chk("t6_pkt_count", 64'(pkt_count), 64'({16'd2, 16'd3}));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
